key_pulse_conditioner: RTL and testbench



---
 rtl/key_pulse_conditioner_if.sv | 26 ++
 rtl/key_pulse_conditioner.sv | 143 ++++++++++++++
 tb/tb_key_pulse_conditioner.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_pulse_conditioner_if.sv
// rtl/key_pulse_conditioner_if.sv - key inputs and command pulse outputs of the key conditioner
interface key_pulse_conditioner_if #(
    parameter int N_KEYS = 2
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] repeat_en;
    logic [N_KEYS-1:0] pulse;
    logic [N_KEYS-1:0] held;
    logic              any_pulse;

    modport master (
        output key_n,
        output repeat_en,
        input  pulse,
        input  held,
        input  any_pulse
    );

    modport slave (
        input  key_n,
        input  repeat_en,
        output pulse,
        output held,
        output any_pulse
    );
endinterface

// File: rtl/key_pulse_conditioner.sv
// rtl/key_pulse_conditioner.sv - push-button synchroniser, debouncer and hold-to-repeat pulse generator
module key_pulse_conditioner #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input logic                    clk,
    input logic                    reset,
    key_pulse_conditioner_if.slave bus
);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST         = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ZERO        = '0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    logic [N_KEYS-1:0] sync_q1;
    logic [N_KEYS-1:0] sync_q2;
    logic [N_KEYS-1:0] pulse_q;
    logic [N_KEYS-1:0] held_q;

    // Keys are inverted at the first flop so everything downstream is active-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= ~bus.key_n;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        state_t           state_q;
        state_t           state_d;
        logic [DB_W-1:0]  db_cnt_q;
        logic [DB_W-1:0]  db_cnt_d;
        logic [RPT_W-1:0] rpt_cnt_q;
        logic [RPT_W-1:0] rpt_cnt_d;
        logic             pulse_r;
        logic             pulse_d;
        logic             held_r;
        logic             held_d;
        logic             s;
        logic             rpt_en;

        assign s      = sync_q2[k];
        assign rpt_en = bus.repeat_en[k];

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= IDLE;
                db_cnt_q  <= '0;
                rpt_cnt_q <= '0;
                pulse_r   <= 1'b0;
                held_r    <= 1'b0;
            end else begin
                state_q   <= state_d;
                db_cnt_q  <= db_cnt_d;
                rpt_cnt_q <= rpt_cnt_d;
                pulse_r   <= pulse_d;
                held_r    <= held_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            db_cnt_d  = db_cnt_q;
            rpt_cnt_d = rpt_cnt_q;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d  = PRESS_DB;
                        db_cnt_d = '0;
                    end
                end
                PRESS_DB: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d   = HELD;
                        rpt_cnt_d = RPT_DELAY_LOAD;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_d  = RELEASE_DB;
                        db_cnt_d = '0;
                    end else if (!rpt_en) begin
                        rpt_cnt_d = RPT_DELAY_LOAD;
                    end else if (rpt_cnt_q == RPT_ZERO) begin
                        rpt_cnt_d = RPT_PERIOD_LOAD;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q - 1'b1;
                    end
                end
                RELEASE_DB: begin
                    // A short release glitch resumes the repeat schedule where it stopped.
                    if (s) begin
                        state_d = HELD;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d = IDLE;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        always_comb begin
            pulse_d = 1'b0;
            held_d  = (state_d == HELD) || (state_d == RELEASE_DB);
            if (state_q == PRESS_DB && s && db_cnt_q == DB_LAST) begin
                pulse_d = 1'b1;
            end else if (state_q == HELD && s && rpt_en && rpt_cnt_q == RPT_ZERO) begin
                pulse_d = 1'b1;
            end
        end

        assign pulse_q[k] = pulse_r;
        assign held_q[k]  = held_r;
    end

    assign bus.pulse     = pulse_q;
    assign bus.held      = held_q;
    assign bus.any_pulse = |pulse_q;
endmodule

// File: tb/tb_key_pulse_conditioner.sv
// tb/tb_key_pulse_conditioner.sv - randomized and directed check of key_pulse_conditioner against a behavioural model
module tb_key_pulse_conditioner;
    localparam int NK = 2;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   pe    = 0;
    int   checks = 0;
    int   errors = 0;

    key_pulse_conditioner_if #(.N_KEYS(NK)) bus ();

    key_pulse_conditioner #(
        .N_KEYS(NK),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic          smp_reset = 1'b1;
    logic [NK-1:0] smp_kn    = '1;
    logic [NK-1:0] smp_en    = '0;

    always @(posedge clk) begin
        pe        <= pe + 1;
        smp_reset <= reset;
        smp_kn    <= bus.key_n;
        smp_en    <= bus.repeat_en;
    end

    // Model: a key's debounced level flips once D+1 consecutive synchronised
    // samples disagree with it; repeats fire on the Nth fully-held enabled edge.
    bit [NK-1:0] m_p1, m_p2, m_lvl, m_sprev, m_pulse;
    int          m_run  [NK];
    int          m_q    [NK];
    int          m_need [NK];
    int          pq0[$];
    int          pq1[$];

    always @(negedge clk) begin : model_and_compare
        bit s;
        if (smp_reset) begin
            m_p1 = '0; m_p2 = '0; m_lvl = '0; m_sprev = '0; m_pulse = '0;
            for (int k = 0; k < NK; k++) begin
                m_run[k] = 0; m_q[k] = 0; m_need[k] = RD;
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                s = m_p2[k];
                m_p2[k] = m_p1[k];
                m_p1[k] = ~smp_kn[k];
                m_pulse[k] = 1'b0;
                if (s != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D + 1) begin
                        m_lvl[k] = s;
                        m_run[k] = 0;
                        if (s) begin
                            m_pulse[k] = 1'b1;
                            m_q[k] = 0;
                            m_need[k] = RD;
                        end
                    end
                end else begin
                    m_run[k] = 0;
                    if (m_lvl[k] && m_sprev[k]) begin
                        if (smp_en[k]) begin
                            m_q[k]++;
                            if (m_q[k] == m_need[k]) begin
                                m_pulse[k] = 1'b1;
                                m_q[k] = 0;
                                m_need[k] = RP;
                            end
                        end else begin
                            m_q[k] = 0;
                            m_need[k] = RD;
                        end
                    end
                end
                m_sprev[k] = s;
            end
            if (m_pulse[0]) pq0.push_back(pe);
            if (m_pulse[1]) pq1.push_back(pe);
        end
        checks++;
        if (bus.pulse !== m_pulse) begin
            errors++;
            $display("FAIL pulse @edge %0d: got %b expected %b", pe, bus.pulse, m_pulse);
        end
        checks++;
        if (bus.held !== m_lvl) begin
            errors++;
            $display("FAIL held @edge %0d: got %b expected %b", pe, bus.held, m_lvl);
        end
        checks++;
        if (bus.any_pulse !== (|m_pulse)) begin
            errors++;
            $display("FAIL any_pulse @edge %0d: got %b expected %b", pe, bus.any_pulse, |m_pulse);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int first_off(input int q[$], input int base);
        return (q.size() > 0) ? q[0] - base : -1;
    endfunction

    int e0, p, f, r, cnt;
    int rexp[8] = '{0, 10, 13, 16, 19, 22, 25, 28};

    initial begin
        bus.key_n     = 2'b11;
        bus.repeat_en = 2'b00;
        reset         = 1'b1;
        step(3);
        chk_int("reset_pulse", int'(bus.pulse), 0);
        chk_int("reset_held", int'(bus.held), 0);
        chk_int("reset_any", int'(bus.any_pulse), 0);
        reset = 1'b0;
        step(2);

        // clean press on key 0
        pq0.delete(); pq1.delete();
        bus.key_n = 2'b10; e0 = pe + 1;
        step(20);
        chk_int("clean_count", pq0.size(), 1);
        chk_int("clean_latency", first_off(pq0, e0), D + 2);
        chk_int("clean_key1_quiet", pq1.size(), 0);
        chk_int("clean_held", int'(bus.held[0]), 1);
        bus.key_n = 2'b11;
        step(12);
        chk_int("clean_released", int'(bus.held[0]), 0);

        // bounce that never settles, then bounce that settles low
        pq0.delete();
        bus.key_n[0] = 1'b0; step(3);
        bus.key_n[0] = 1'b1; step(1);
        bus.key_n[0] = 1'b0; step(3);
        bus.key_n[0] = 1'b1; step(12);
        chk_int("bounce_reject", pq0.size(), 0);
        bus.key_n[0] = 1'b0; step(3);
        bus.key_n[0] = 1'b1; step(1);
        bus.key_n[0] = 1'b0; f = pe + 1;
        step(15);
        chk_int("bounce_settle_count", pq0.size(), 1);
        chk_int("bounce_settle_latency", first_off(pq0, f), D + 2);
        bus.key_n[0] = 1'b1; step(12);

        // auto-repeat enabled: release sampled at P+28 so the last repeat is P+28
        pq0.delete();
        bus.repeat_en = 2'b01;
        bus.key_n[0] = 1'b0; e0 = pe + 1; p = e0 + D + 2;
        step(p + 27 - pe);
        bus.key_n[0] = 1'b1;
        step(12);
        chk_int("repeat_count", pq0.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_int($sformatf("repeat_offset_%0d", i), (i < pq0.size()) ? pq0[i] - p : -1, rexp[i]);

        // auto-repeat disabled
        pq0.delete();
        bus.repeat_en = 2'b00;
        bus.key_n[0] = 1'b0; e0 = pe + 1; p = e0 + D + 2;
        step(p + 30 - pe);
        bus.key_n[0] = 1'b1;
        step(12);
        chk_int("norepeat_count", pq0.size(), 1);
        chk_int("norepeat_at", first_off(pq0, p), 0);

        // release glitch while held, then real release and re-press
        pq0.delete();
        bus.repeat_en = 2'b01;
        bus.key_n[0] = 1'b0; e0 = pe + 1; p = e0 + D + 2;
        step(p + 3 - pe);
        bus.key_n[0] = 1'b1; step(2);
        bus.key_n[0] = 1'b0; step(20);
        chk_int("glitch_held", int'(bus.held[0]), 1);
        cnt = 0;
        foreach (pq0[i]) if (pq0[i] > p && pq0[i] <= p + RD) cnt++;
        chk_int("glitch_no_extra", cnt, 0);
        bus.key_n[0] = 1'b1; step(10);
        chk_int("glitch_release_held", int'(bus.held[0]), 0);
        pq0.delete();
        bus.key_n[0] = 1'b0; e0 = pe + 1;
        step(10);
        chk_int("repress_count", pq0.size(), 1);
        chk_int("repress_latency", first_off(pq0, e0), D + 2);
        bus.key_n[0] = 1'b1; bus.repeat_en = 2'b00;
        step(12);

        // simultaneous press on both keys
        pq0.delete(); pq1.delete();
        bus.key_n = 2'b00; e0 = pe + 1;
        step(10);
        chk_int("simul_k0", first_off(pq0, e0), D + 2);
        chk_int("simul_k1", first_off(pq1, e0), D + 2);
        bus.key_n = 2'b11;
        step(12);

        // reset while key 0 is held
        bus.key_n[0] = 1'b0;
        step(12);
        chk_int("prereset_held", int'(bus.held[0]), 1);
        reset = 1'b1; r = pe + 1;
        step(1);
        chk_int("midreset_pulse", int'(bus.pulse), 0);
        chk_int("midreset_held", int'(bus.held), 0);
        reset = 1'b0;
        pq0.delete();
        step(12);
        chk_int("postreset_count", pq0.size(), 1);
        chk_int("postreset_latency", first_off(pq0, r + 1), D + 2);
        bus.key_n = 2'b11;
        step(12);

        // randomized phase, checked cycle by cycle against the model
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 2) == 0) bus.key_n[k] = ~bus.key_n[k];
            if ($urandom_range(0, 5) == 0) bus.repeat_en = 2'($urandom);
            reset = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 3) == 0) step($urandom_range(8, 30));
            else step($urandom_range(1, 6));
        end
        reset = 1'b0;
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
